// File: rtl/dds_sequencer.sv
// dds_sequencer
// Phase-accumulator controller for a quarter-wave DDS datapath. It holds the
// frequency control word, divides the clock down to the sample rate and runs
// either free-running or for a counted burst. The phase is kept between runs.
//
// Ports:
//   clk, rst_n          clock (rising edge), asynchronous active-low reset
//   start, stop         begin a run from IDLE / end a run from RUN
//   burst_mode          1 = stop after burst_len samples (latched at start)
//   burst_len           samples per burst
//   div_in              sample period in clocks (0 behaves as 1)
//   fcw_in, fcw_load    new frequency control word and its capture strobe
//   phase_clr           zero the accumulator
//   phase_ofs           (only with DDS_PHASE_OFFSET_EN) phase offset added
//                       to the accumulator when forming the output fields
//   sign_bit            accumulator MSB (lower half-cycle)
//   phase_pose          accumulator MSB-1 (mirrored quarter)
//   addr                quarter-wave ROM address field
//   sample_valid        one-cycle pulse when the fields above are new
//   busy                high while running
//   done                one-cycle pulse when a run ends
//
// Build option: define DDS_PHASE_OFFSET_EN to add the phase_ofs input.
module dds_sequencer #(
  parameter int ACC_W  = 16,
  parameter int ADDR_W = 6,
  parameter int CNT_W  = 16,
  parameter int DIV_W  = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic              stop,
  input  logic              burst_mode,
  input  logic [CNT_W-1:0]  burst_len,
  input  logic [DIV_W-1:0]  div_in,
  input  logic [ACC_W-1:0]  fcw_in,
  input  logic              fcw_load,
  input  logic              phase_clr,
`ifdef DDS_PHASE_OFFSET_EN
  input  logic [ACC_W-1:0]  phase_ofs,
`endif
  output logic              sign_bit,
  output logic              phase_pose,
  output logic [ADDR_W-1:0] addr,
  output logic              sample_valid,
  output logic              busy,
  output logic              done
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  state_t             r_state;
  state_t             w_state_nxt;
  logic [ACC_W-1:0]   r_acc;
  logic [ACC_W-1:0]   r_fcw_act;
  logic [ACC_W-1:0]   r_fcw_shadow;
  logic [DIV_W-1:0]   r_div_cnt;
  logic [CNT_W-1:0]   r_samp_cnt;
  logic               r_burst;
  logic               r_sign;
  logic               r_pose;
  logic [ADDR_W-1:0]  r_addr;
  logic               r_valid;
  logic               r_busy;
  logic               r_done;

  logic               w_tick;
  logic [DIV_W-1:0]   w_div_last;
  logic [CNT_W:0]     w_samp_nxt;
  logic               w_burst_end;
  logic [ACC_W-1:0]   w_phase;

  // Last divider count of a sample period; a period of 0 behaves as 1.
  assign w_div_last  = (div_in == {DIV_W{1'b0}}) ? {DIV_W{1'b0}}
                                                 : div_in - {{(DIV_W-1){1'b0}}, 1'b1};
  // One extra bit so the count never wraps before the compare.
  assign w_samp_nxt  = {1'b0, r_samp_cnt} + {{CNT_W{1'b0}}, 1'b1};
  assign w_burst_end = (w_samp_nxt == {1'b0, burst_len});

`ifdef DDS_PHASE_OFFSET_EN
  assign w_phase = r_acc + phase_ofs;
`else
  assign w_phase = r_acc;
`endif

  // Next-state logic and sample tick decode; stop pre-empts a coincident tick.
  always_comb begin
    w_state_nxt = r_state;
    w_tick      = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (start) begin
          if (burst_mode && (burst_len == {CNT_W{1'b0}})) begin
            w_state_nxt = ST_DONE;
          end else begin
            w_state_nxt = ST_RUN;
          end
        end else begin
          w_state_nxt = ST_IDLE;
        end
      end
      ST_RUN: begin
        if (stop) begin
          w_state_nxt = ST_DONE;
        end else if (r_div_cnt == {DIV_W{1'b0}}) begin
          w_tick = 1'b1;
          if (r_burst && w_burst_end) begin
            w_state_nxt = ST_DONE;
          end else begin
            w_state_nxt = ST_RUN;
          end
        end else begin
          w_state_nxt = ST_RUN;
        end
      end
      ST_DONE: w_state_nxt = ST_IDLE;
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  // State register and registered status outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= ST_IDLE;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
      r_valid <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_busy  <= (w_state_nxt == ST_RUN);
      r_done  <= (w_state_nxt == ST_DONE);
      r_valid <= w_tick;
    end
  end

  // Divider, sample counter and burst-mode latch.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_div_cnt  <= {DIV_W{1'b0}};
      r_samp_cnt <= {CNT_W{1'b0}};
      r_burst    <= 1'b0;
    end else if (r_state == ST_IDLE) begin
      if (start) begin
        r_div_cnt  <= {DIV_W{1'b0}};
        r_samp_cnt <= {CNT_W{1'b0}};
        r_burst    <= burst_mode;
      end
    end else if (r_state == ST_RUN) begin
      r_div_cnt <= (r_div_cnt >= w_div_last) ? {DIV_W{1'b0}}
                                             : r_div_cnt + {{(DIV_W-1){1'b0}}, 1'b1};
      if (w_tick) begin
        r_samp_cnt <= w_samp_nxt[CNT_W-1:0];
      end
    end
  end

  // FCW shadow/active registers; a run only switches frequency on a tick so
  // the add on that tick still uses the previous word.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_fcw_act    <= {ACC_W{1'b0}};
      r_fcw_shadow <= {ACC_W{1'b0}};
    end else begin
      if (fcw_load) begin
        r_fcw_shadow <= fcw_in;
      end
      if ((r_state == ST_IDLE) && fcw_load) begin
        r_fcw_act <= fcw_in;
      end else if (w_tick) begin
        r_fcw_act <= fcw_load ? fcw_in : r_fcw_shadow;
      end
    end
  end

  // Phase accumulator; a clear wins over a coincident add.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_acc <= {ACC_W{1'b0}};
    end else if (phase_clr) begin
      r_acc <= {ACC_W{1'b0}};
    end else if (w_tick) begin
      r_acc <= r_acc + r_fcw_act;
    end
  end

  // Output fields captured from the pre-add phase on each tick.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_sign <= 1'b0;
      r_pose <= 1'b0;
      r_addr <= {ADDR_W{1'b0}};
    end else if (w_tick) begin
      r_sign <= w_phase[ACC_W-1];
      r_pose <= w_phase[ACC_W-2];
      r_addr <= w_phase[ACC_W-3 -: ADDR_W];
    end
  end

  assign sign_bit     = r_sign;
  assign phase_pose   = r_pose;
  assign addr         = r_addr;
  assign sample_valid = r_valid;
  assign busy         = r_busy;
  assign done         = r_done;

endmodule
